// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and controller: bus constants,
// target FSM state encoding and address-match helper.
package i2c_pkg;

   localparam int   I2C_ADDR_W  = 7;
   localparam logic I2C_RW_READ = 1'b1;
   localparam logic I2C_ACK     = 1'b0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR,
      ST_WR_ACK,
      ST_RD,
      ST_RD_ACK,
      ST_IGNORE
   } i2c_state_e;

   // General call (address 0) never matches, even if configured as the device address.
   function automatic logic addr_match(input logic [I2C_ADDR_W-1:0] rx,
                                       input logic [I2C_ADDR_W-1:0] dev);
      return (rx == dev) && (rx != '0);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA pad conditioning: 2-flop synchronizers plus a delay stage, producing
// SCL edge strobes, START/STOP strobes and the synchronized SDA level.
module i2c_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic sda_o
);

   logic scl_meta_q, scl_sync_q, scl_dly_q;
   logic sda_meta_q, sda_sync_q, sda_dly_q;

   // Reset to the idle (released, high) bus level so no edge is seen out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_dly_q  <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_dly_q  <= 1'b1;
      end else begin
         scl_meta_q <= scl_i;
         scl_sync_q <= scl_meta_q;
         scl_dly_q  <= scl_sync_q;
         sda_meta_q <= sda_i;
         sda_sync_q <= sda_meta_q;
         sda_dly_q  <= sda_sync_q;
      end
   end

   assign scl_rise_o = scl_sync_q & ~scl_dly_q;
   assign scl_fall_o = ~scl_sync_q & scl_dly_q;
   assign start_o    = scl_sync_q & scl_dly_q & sda_dly_q & ~sda_sync_q;
   assign stop_o     = scl_sync_q & scl_dly_q & ~sda_dly_q & sda_sync_q;
   assign sda_o      = sda_sync_q;

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target with an auto-incrementing byte register-bank port.
// Bits are sampled on SCL rise; SDA is only changed right after an SCL fall.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] DEVICE_ADDR = 7'h50
) (
   input  logic       controlClock,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   logic scl_rise, scl_fall, start, stop, sda_s;

   i2c_line_sync u_sync (
      .clk_i      (controlClock),
      .rst_i      (reset),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start),
      .stop_o     (stop),
      .sda_o      (sda_s)
   );

   i2c_state_e state_q;
   logic [3:0] bitcnt_q;
   logic [7:0] shift_q;
   logic [7:0] reg_addr_q;
   logic [7:0] reg_wdata_q;
   logic       reg_we_q;
   logic       sda_oe_q;
   logic       busy_q;
   logic       rw_q;

   always_ff @(posedge controlClock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bitcnt_q    <= 4'd0;
         shift_q     <= 8'h00;
         reg_addr_q  <= 8'h00;
         reg_wdata_q <= 8'h00;
         reg_we_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         rw_q        <= 1'b0;
      end else begin
         reg_we_q <= 1'b0;
         // Pointer advances the cycle after each write strobe.
         if (reg_we_q)
            reg_addr_q <= reg_addr_q + 8'd1;

         if (stop) begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            bitcnt_q <= 4'd0;
         end else if (start) begin
            state_q  <= ST_ADDR;
            sda_oe_q <= 1'b0;
            bitcnt_q <= 4'd0;
         end else begin
            case (state_q)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_q  <= {shift_q[6:0], sda_s};
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end else if (scl_fall && bitcnt_q == 4'd8) begin
                     bitcnt_q <= 4'd0;
                     if (addr_match(shift_q[7:1], DEVICE_ADDR)) begin
                        rw_q     <= shift_q[0];
                        busy_q   <= 1'b1;
                        sda_oe_q <= 1'b1;
                        state_q  <= ST_ADDR_ACK;
                     end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IGNORE;
                     end
                  end
               end

               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (rw_q == I2C_RW_READ) begin
                        shift_q  <= reg_rdata;
                        sda_oe_q <= ~reg_rdata[7];
                        state_q  <= ST_RD;
                     end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_PTR;
                     end
                  end
               end

               ST_PTR: begin
                  if (scl_rise) begin
                     shift_q  <= {shift_q[6:0], sda_s};
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end else if (scl_fall && bitcnt_q == 4'd8) begin
                     bitcnt_q   <= 4'd0;
                     reg_addr_q <= shift_q;
                     sda_oe_q   <= 1'b1;
                     state_q    <= ST_PTR_ACK;
                  end
               end

               ST_PTR_ACK, ST_WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= ST_WR;
                  end
               end

               ST_WR: begin
                  if (scl_rise) begin
                     shift_q  <= {shift_q[6:0], sda_s};
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end else if (scl_fall && bitcnt_q == 4'd8) begin
                     bitcnt_q    <= 4'd0;
                     reg_wdata_q <= shift_q;
                     reg_we_q    <= 1'b1;
                     sda_oe_q    <= 1'b1;
                     state_q     <= ST_WR_ACK;
                  end
               end

               // shift_q[7] is the bit currently on the bus; the next one is presented on each fall.
               ST_RD: begin
                  if (scl_rise) begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bitcnt_q == 4'd8) begin
                        bitcnt_q <= 4'd0;
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_RD_ACK;
                     end else begin
                        sda_oe_q <= ~shift_q[6];
                        shift_q  <= {shift_q[6:0], 1'b0};
                     end
                  end
               end

               // Pointer moves on the ACK rise so reg_rdata has settled by the fall that loads it.
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_s == I2C_ACK)
                        reg_addr_q <= reg_addr_q + 8'd1;
                     else
                        state_q <= ST_IGNORE;
                  end else if (scl_fall) begin
                     shift_q  <= reg_rdata;
                     sda_oe_q <= ~reg_rdata[7];
                     state_q  <= ST_RD;
                  end
               end

               default: begin
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_we    = reg_we_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bench acts as the bus master and hosts a
// 256-byte register bank behind the target's register port.
module tb_i2c_target;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_m, sda_m;
   logic       sda_bus;
   logic       sda_oe;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, busy;

   int errors = 0;
   int checks = 0;

   logic [7:0]  bank [256];
   logic [15:0] wlog [$];
   int          we_cnt = 0;
   int          oe_cnt = 0;

   always #5 clk = ~clk;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_target #(.DEVICE_ADDR(7'h50)) dut (
      .controlClock (clk),
      .reset        (reset),
      .scl_in       (scl_m),
      .sda_in       (sda_bus),
      .sda_oe       (sda_oe),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_we       (reg_we),
      .reg_rdata    (reg_rdata),
      .busy         (busy)
   );

   // Register bank: reset pattern bank[i] = ~i, registered read data.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) bank[i] <= 8'(~i);
      end else if (reg_we) begin
         bank[reg_addr] <= reg_wdata;
         wlog.push_back({reg_addr, reg_wdata});
         we_cnt <= we_cnt + 1;
      end
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      reg_rdata <= bank[reg_addr];
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; scl_m = 1'b1; tick(10);
      sda_m = 1'b0; tick(10);
      scl_m = 1'b0;
   endtask

   task automatic i2c_rstart();
      tick(5); sda_m = 1'b1; tick(5);
      scl_m = 1'b1; tick(10);
      sda_m = 1'b0; tick(10);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(5); sda_m = 1'b0; tick(5);
      scl_m = 1'b1; tick(10);
      sda_m = 1'b1; tick(10);
   endtask

   task automatic clk_bit(input logic val, output logic smp);
      tick(5); sda_m = val; tick(5);
      scl_m = 1'b1; tick(5);
      smp = sda_bus; tick(5);
      scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic d;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
      clk_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic do_ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         b[i] = s;
      end
      clk_bit(do_ack ? 1'b0 : 1'b1, s);
   endtask

   task automatic test_reset();
      reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      tick(3);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got=%b exp=0", reg_we); end
      checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got=%h exp=00", reg_addr); end
      checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata got=%h exp=00", reg_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      reset = 1'b0;
      tick(10);
   endtask

   task automatic test_write();
      logic a0, a1, a2, a3;
      int   base;
      base = wlog.size();
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h10, a1);
      write_byte(8'hA5, a2);
      write_byte(8'h3C, a3);
      checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wr_acks got=%b exp=0000", {a0, a1, a2, a3}); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_active got=%b exp=1", busy); end
      i2c_stop();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got=%b exp=0", busy); end
      checks++; if (wlog.size() !== base + 2) begin errors++; $display("FAIL wr_count got=%0d exp=%0d", wlog.size() - base, 2); end
      if (wlog.size() >= base + 2) begin
         checks++; if (wlog[base] !== 16'h10A5) begin errors++; $display("FAIL wr_first got=%h exp=10a5", wlog[base]); end
         checks++; if (wlog[base+1] !== 16'h113C) begin errors++; $display("FAIL wr_second got=%h exp=113c", wlog[base+1]); end
      end
      checks++; if (reg_addr !== 8'h12) begin errors++; $display("FAIL wr_ptr_after got=%h exp=12", reg_addr); end
   endtask

   task automatic test_read();
      logic       a0, a1, a2;
      logic [7:0] d0, d1;
      int         oe0;
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h20, a1);
      i2c_rstart();
      write_byte(8'hA1, a2);
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rd_acks got=%b exp=000", {a0, a1, a2}); end
      read_byte(1'b1, d0);
      read_byte(1'b0, d1);
      checks++; if (d0 !== 8'hDF) begin errors++; $display("FAIL rd_byte0 got=%h exp=df", d0); end
      checks++; if (d1 !== 8'hDE) begin errors++; $display("FAIL rd_byte1 got=%h exp=de", d1); end
      tick(5);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release got=%b exp=0", sda_oe); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_nack got=%b exp=1", busy); end
      oe0 = oe_cnt;
      i2c_stop();
      checks++; if (oe_cnt !== oe0) begin errors++; $display("FAIL rd_oe_after_nack got=%0d exp=%0d", oe_cnt, oe0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_stop got=%b exp=0", busy); end
      checks++; if (reg_addr !== 8'h21) begin errors++; $display("FAIL rd_ptr got=%h exp=21", reg_addr); end
   endtask

   task automatic test_nomatch();
      logic a0, a1, a2;
      int   we0, oe0;
      we0 = we_cnt; oe0 = oe_cnt;
      i2c_start();
      write_byte(8'hA2, a0);
      write_byte(8'h55, a1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nm_busy got=%b exp=0", busy); end
      i2c_stop();
      i2c_start();
      write_byte(8'h00, a2);
      i2c_stop();
      checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL nm_nack got=%b exp=11", {a0, a1}); end
      checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL nm_gencall got=%b exp=1", a2); end
      checks++; if (oe_cnt !== oe0) begin errors++; $display("FAIL nm_oe got=%0d exp=%0d", oe_cnt, oe0); end
      checks++; if (we_cnt !== we0) begin errors++; $display("FAIL nm_we got=%0d exp=%0d", we_cnt, we0); end
   endtask

   task automatic test_wrap();
      logic a0, a1, a2, a3;
      int   base;
      base = wlog.size();
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'hFF, a1);
      write_byte(8'h11, a2);
      write_byte(8'h22, a3);
      i2c_stop();
      checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks got=%b exp=0000", {a0, a1, a2, a3}); end
      checks++; if (wlog.size() !== base + 2) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", wlog.size() - base, 2); end
      if (wlog.size() >= base + 2) begin
         checks++; if (wlog[base] !== 16'hFF11) begin errors++; $display("FAIL wrap_first got=%h exp=ff11", wlog[base]); end
         checks++; if (wlog[base+1] !== 16'h0022) begin errors++; $display("FAIL wrap_second got=%h exp=0022", wlog[base+1]); end
      end
      checks++; if (reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr got=%h exp=01", reg_addr); end
   endtask

   task automatic test_stop_mid();
      logic a0, a1, d;
      int   we0;
      we0 = we_cnt;
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h30, a1);
      clk_bit(1'b1, d);
      clk_bit(1'b0, d);
      clk_bit(1'b1, d);
      clk_bit(1'b1, d);
      i2c_stop();
      checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL mid_acks got=%b exp=00", {a0, a1}); end
      checks++; if (we_cnt !== we0) begin errors++; $display("FAIL mid_we got=%0d exp=%0d", we_cnt, we0); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mid_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (reg_addr !== 8'h30) begin errors++; $display("FAIL mid_ptr got=%h exp=30", reg_addr); end
   endtask

   task automatic test_reset_ack();
      logic d, a0, a1, a2;
      logic [7:0] b;
      int   base;
      b = 8'hA0;
      i2c_start();
      for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
      tick(5);
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_ack_driven got=%b exp=1", sda_oe); end
      reset = 1'b1;
      tick(1);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_ack_release got=%b exp=0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_ack_busy got=%b exp=0", busy); end
      checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rst_ack_ptr got=%h exp=00", reg_addr); end
      reset = 1'b0;
      tick(4); sda_m = 1'b1; tick(5);
      scl_m = 1'b1; tick(10);
      scl_m = 1'b0;
      i2c_stop();
      base = wlog.size();
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h40, a1);
      write_byte(8'h77, a2);
      i2c_stop();
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rst_next_acks got=%b exp=000", {a0, a1, a2}); end
      checks++; if (wlog.size() !== base + 1) begin errors++; $display("FAIL rst_next_count got=%0d exp=1", wlog.size() - base); end
      if (wlog.size() >= base + 1) begin
         checks++; if (wlog[base] !== 16'h4077) begin errors++; $display("FAIL rst_next_write got=%h exp=4077", wlog[base]); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nomatch();
      test_wrap();
      test_stop_mid();
      test_reset_ack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
# i2c_target

Single-address I2C target (responder) that answers transactions issued by the team's I2C controller or any standard-mode master. It oversamples SCL/SDA on the system clock, decodes START/STOP, address, and data bytes, and drives SDA open-drain for ACK and read data. It exposes a byte-wide register-bank port with an auto-incrementing pointer, so any local register file can sit behind the bus.

## Interface
- DEVICE_ADDR, 7'h50, 7-bit bus address this target answers to
- controlClock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- scl_in  in  1  raw SCL pad input, asynchronous
- sda_in  in  1  raw SDA pad input, asynchronous
- sda_oe  out  1  1 = pull SDA low; 0 = release. Pad ties SDA output to 0.
- reg_addr  out  8  register pointer
- reg_wdata  out  8  byte received from master
- reg_we  out  1  one-cycle write strobe
- reg_rdata  in  8  register contents at reg_addr; valid the cycle after reg_addr changes
- busy  out  1  high from address match until STOP or non-matching repeated START

## Operation
- Line conditioning: 2-flop synchronizer on scl_in/sda_in plus one delay stage; edges are detected on synchronized values.
- START = SDA falling while SCL high; STOP = SDA rising while SCL high. Both take priority over bit handling in every state.
- Bits sampled on SCL rising edge, MSB first; SDA (sda_oe) updated only on the cycle after an SCL falling edge is detected.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- IDLE --START--> ADDR. After 8 bits: address match → ADDR_ACK (drive ACK low for the 9th clock), busy=1; mismatch → IGNORE.
- ADDR_ACK: R/W=0 → PTR; R/W=1 → RD, with first byte loaded from reg_rdata.
- PTR: byte received → reg_addr, ACK → WR.
- WR: after the 8th bit, reg_wdata=byte and reg_we=1 for one cycle at current reg_addr; ACK; reg_addr increments the cycle after reg_we.
- RD: shift byte out; release SDA for the 9th clock → RD_ACK. RD_ACK: master ACK (SDA low) → reg_addr+1, load next byte, back to RD. Master NACK → IGNORE.
- IGNORE: sda_oe=0; wait for START (→ ADDR) or STOP (→ IDLE).
- Any STOP → IDLE, sda_oe=0 within one cycle, busy=0. Repeated START in any state → ADDR; reg_addr is retained, so write-pointer-then-restart-read works.
- Pointer wraps 8'hFF → 8'h00. No clock stretching. General call (addr 0) is not acknowledged.

## Timing
- Reset values: sda_oe=0, reg_we=0, reg_addr=8'h00, reg_wdata=8'h00, busy=0, state IDLE.
- Input-to-decision latency: 3 controlClock cycles from pad edge.
- Requirement: SCL high and low phases each ≥ 6 controlClock cycles, and master SDA hold ≥ 4 cycles after SCL fall.
- ACK: sda_oe asserted 1 cycle after the detected 8th SCL fall and released 1 cycle after the detected 9th SCL fall.
- Read data: reg_addr update precedes byte load by ≥ 1 cycle.
- reset asserted mid-transfer: all outputs return to reset values next edge; the bus is released immediately.

## Structure
- i2c_pkg: state enum, I2C_ADDR_W=7, I2C_RW_READ=1'b1, ACK=1'b0 constants; shared with the controller.
- Sub-module i2c_line_sync: synchronizers, scl_rise/scl_fall strobes, start/stop strobes, synchronized sda.
- Top holds FSM, bit counter (0–8), shift register, and pointer.

## Test plan
- Write 0x50+W, ptr 0x10, data 0xA5, 0x3C, STOP → ACK on all 4 bytes; reg_we pulses with (0x10,0xA5), (0x11,0x3C); busy drops on STOP.
- Write ptr 0x20, repeated START, 0x50+R, master ACK then NACK → SDA carries bank[0x20], bank[0x21]; target releases after NACK.
- Address 0x51 → no ACK, sda_oe stays 0 through STOP, no reg_we, busy=0.
- Ptr 0xFF, write 0x11, 0x22 → writes land at 0xFF and 0x00.
- STOP injected after bit 4 of a data byte → no reg_we, IDLE, sda_oe=0.
- reset pulsed during ACK → sda_oe=0 next cycle; next full transaction succeeds.
